// File: rtl/store_buffer_pkg.sv
// Shared types and sizing for the posted-write store buffer.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } sb_entry_t;

endpackage

// File: rtl/store_merge_unit.sv
// Per-lane byte merge of an incoming store into an existing buffer entry.
module store_merge_unit (
  input  logic [3:0]  old_wstrb,
  input  logic [31:0] old_wdata,
  input  logic [3:0]  st_wstrb,
  input  logic [31:0] st_wdata,
  output logic [3:0]  merged_wstrb,
  output logic [31:0] merged_wdata
);

  always_comb begin
    merged_wstrb = old_wstrb | st_wstrb;
    merged_wdata = old_wdata;
    for (int i = 0; i < 4; i++) begin
      if (st_wstrb[i]) begin
        merged_wdata[8*i +: 8] = st_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order posted-write buffer: merges back-to-back stores to the youngest word,
// drains over a valid/ready channel and flags loads that hit a pending word.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_wstrb,
  input  logic [31:0] st_wdata,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_wstrb,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_req_ready,
  output logic        sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t          entries_q [DEPTH];
  sb_entry_t          entries_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [PTR_W-1:0]   young_idx;
  logic               merge_hit;
  logic               full;
  logic               push;
  logic               pop;
  logic [3:0]         merged_wstrb;
  logic [31:0]        merged_wdata;
  logic [PTR_W-1:0]   offset;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  assign young_idx     = tail_q - PTR_W'(1);
  assign full          = (count_q == CNT_W'(DEPTH));
  assign mem_req_valid = (count_q != '0);
  assign sb_empty      = (count_q == '0);

  // The head is excluded from merging while it is on the bus so the payload
  // stays stable during backpressure.
  assign merge_hit = (count_q != '0) &&
                     (entries_q[young_idx].waddr == st_addr[31:2]) &&
                     !((young_idx == head_q) && mem_req_valid);

  assign st_ready = !full || merge_hit;
  assign push     = st_valid && st_ready && (st_wstrb != 4'b0000);
  assign pop      = mem_req_valid && mem_req_ready;

  assign mem_req_addr  = {entries_q[head_q].waddr, 2'b00};
  assign mem_req_wstrb = entries_q[head_q].wstrb;
  assign mem_req_wdata = entries_q[head_q].wdata;

  store_merge_unit u_merge (
    .old_wstrb    (entries_q[young_idx].wstrb),
    .old_wdata    (entries_q[young_idx].wdata),
    .st_wstrb     (st_wstrb),
    .st_wdata     (st_wdata),
    .merged_wstrb (merged_wstrb),
    .merged_wdata (merged_wdata)
  );

  always_comb begin
    ld_hazard = 1'b0;
    offset    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head_q;
      if (ld_valid && ({1'b0, offset} < count_q) &&
          (entries_q[i].waddr == ld_addr[31:2])) begin
        ld_hazard = 1'b1;
      end
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (push) begin
      if (merge_hit) begin
        entries_d[young_idx].wstrb = merged_wstrb;
        entries_d[young_idx].wdata = merged_wdata;
      end else begin
        entries_d[tail_q] = '{waddr: st_addr[31:2], wstrb: st_wstrb, wdata: st_wdata};
        tail_d            = tail_q + PTR_W'(1);
      end
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    unique case ({push && !merge_hit, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model plus directed scenarios.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_req_wdata;
  logic        mem_req_ready;
  logic        sb_empty;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [29:0] waddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } m_entry_t;

  m_entry_t    mq[$];
  logic [31:0] bus_log[$];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .st_valid      (st_valid),
    .st_addr       (st_addr),
    .st_wstrb      (st_wstrb),
    .st_wdata      (st_wdata),
    .st_ready      (st_ready),
    .ld_valid      (ld_valid),
    .ld_addr       (ld_addr),
    .ld_hazard     (ld_hazard),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_ready (mem_req_ready),
    .sb_empty      (sb_empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a store merges when it targets the youngest pending word and that word is not the one on the bus.
  function automatic bit m_merge();
    return (mq.size() >= 2) && (mq[mq.size()-1].waddr == st_addr[31:2]);
  endfunction

  function automatic bit m_ready();
    return (mq.size() != DEPTH) || m_merge();
  endfunction

  function automatic bit m_hazard();
    bit h = 1'b0;
    foreach (mq[i]) if (mq[i].waddr == ld_addr[31:2]) h = 1'b1;
    return ld_valid && h;
  endfunction

  bit       m_pop, m_mg, m_acc;
  m_entry_t m_e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      if (mem_req_valid && mem_req_ready) bus_log.push_back(mem_req_addr);
      m_pop = (mq.size() != 0) && mem_req_ready;
      m_mg  = m_merge();
      m_acc = st_valid && m_ready() && (st_wstrb != 4'b0000);
      if (m_acc && m_mg) begin
        m_e = mq[mq.size()-1];
        for (int i = 0; i < 4; i++) begin
          if (st_wstrb[i]) begin
            m_e.wstrb[i]       = 1'b1;
            m_e.wdata[8*i +: 8] = st_wdata[8*i +: 8];
          end
        end
        mq[mq.size()-1] = m_e;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_acc && !m_mg) begin
        m_e.waddr = st_addr[31:2];
        m_e.wstrb = st_wstrb;
        m_e.wdata = st_wdata;
        mq.push_back(m_e);
      end
    end
  end

  always @(negedge clk) begin
    chk("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, mq.size() != 0});
    chk("sb_empty",      {31'b0, sb_empty},      {31'b0, mq.size() == 0});
    chk("st_ready",      {31'b0, st_ready},      {31'b0, m_ready()});
    chk("ld_hazard",     {31'b0, ld_hazard},     {31'b0, m_hazard()});
    if (mq.size() != 0) begin
      chk("mem_req_addr",  mem_req_addr,          {mq[0].waddr, 2'b00});
      chk("mem_req_wstrb", {28'b0, mem_req_wstrb}, {28'b0, mq[0].wstrb});
      chk("mem_req_wdata", mem_req_wdata,         mq[0].wdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_wstrb = s;
    st_wdata = d;
    cyc();
    st_valid = 1'b0;
    st_wstrb = 4'b0000;
  endtask

  initial begin
    rst = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_wstrb = '0; st_wdata = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_req_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    ld_valid = 1'b1;
    #1;
    chk("reset_valid",  {31'b0, mem_req_valid}, 32'd0);
    chk("reset_empty",  {31'b0, sb_empty},      32'd1);
    chk("reset_ready",  {31'b0, st_ready},      32'd1);
    chk("reset_hazard", {31'b0, ld_hazard},     32'd0);
    ld_valid = 1'b0;
    cyc();

    // single store
    mem_req_ready = 1'b1;
    store(32'h1000_0004, 4'b0001, 32'h0000_00AB);
    chk("single_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("single_addr",  mem_req_addr,           32'h1000_0004);
    chk("single_wstrb", {28'b0, mem_req_wstrb}, 32'h1);
    chk("single_wdata", mem_req_wdata,          32'h0000_00AB);
    cyc();
    chk("single_empty_after", {31'b0, sb_empty}, 32'd1);

    // merge into youngest
    mem_req_ready = 1'b0;
    store(32'h0000_2000, 4'b0001, 32'h0000_0011);
    store(32'h0000_3000, 4'b0010, 32'h0000_2200);
    store(32'h0000_3000, 4'b1000, 32'h4400_0000);
    chk("merge_count", mq.size(), 32'd2);
    chk("merge_head_addr", mem_req_addr, 32'h0000_2000);
    chk("merge_head_data", mem_req_wdata, 32'h0000_0011);
    mem_req_ready = 1'b1;
    cyc();
    chk("merge_addr",  mem_req_addr,           32'h0000_3000);
    chk("merge_wstrb", {28'b0, mem_req_wstrb}, 32'hA);
    chk("merge_wdata", mem_req_wdata,          32'h4400_2200);
    cyc();
    chk("merge_drained", {31'b0, sb_empty}, 32'd1);

    // full and backpressure
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) store(32'h0000_A000 + 32'(4*k), 4'hF, 32'h100 + 32'(k));
    st_valid = 1'b1; st_addr = 32'h0000_B000; st_wstrb = 4'hF; st_wdata = 32'hDEAD;
    #1 chk("full_ready", {31'b0, st_ready}, 32'd0);
    cyc();
    chk("full_stalled_count", mq.size(), 32'd4);
    st_addr = 32'h0000_A00C; st_wstrb = 4'b0001; st_wdata = 32'h77;
    #1 chk("full_merge_ready", {31'b0, st_ready}, 32'd1);
    cyc();
    st_valid = 1'b0; st_wstrb = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      chk("stall_addr", mem_req_addr,  32'h0000_A000);
      chk("stall_data", mem_req_wdata, 32'h0000_0100);
      cyc();
    end
    mem_req_ready = 1'b1;
    repeat (6) cyc();
    chk("full_drained", {31'b0, sb_empty}, 32'd1);

    // simultaneous push/pop across pointer wrap
    mem_req_ready = 1'b0;
    store(32'h0000_C000, 4'hF, 32'h1);
    store(32'h0000_C004, 4'hF, 32'h2);
    mem_req_ready = 1'b1;
    bus_log.delete();
    for (int k = 0; k < 12; k++) begin
      store(32'h0000_C100 + 32'(16*k), 4'hF, 32'(k));
      chk("pushpop_count", mq.size(), 32'd2);
    end
    repeat (4) cyc();
    chk("wrap_log_size", bus_log.size(), 32'd14);
    for (int k = 0; k < 14; k++) begin
      if (k < bus_log.size())
        chk("wrap_order", bus_log[k],
            (k < 2) ? 32'h0000_C000 + 32'(4*k) : 32'h0000_C100 + 32'(16*(k-2)));
    end

    // load hazard
    mem_req_ready = 1'b0;
    store(32'h0000_4000, 4'hF, 32'h9);
    ld_valid = 1'b1; ld_addr = 32'h0000_4002;
    #1 chk("hazard_hit", {31'b0, ld_hazard}, 32'd1);
    ld_addr = 32'h0000_4004;
    #1 chk("hazard_miss", {31'b0, ld_hazard}, 32'd0);
    mem_req_ready = 1'b1;
    cyc();
    ld_addr = 32'h0000_4002;
    #1 chk("hazard_after_pop", {31'b0, ld_hazard}, 32'd0);
    ld_valid = 1'b0;
    cyc();

    // asynchronous reset mid-drain
    mem_req_ready = 1'b0;
    store(32'h0000_E000, 4'hF, 32'h1);
    store(32'h0000_E004, 4'hF, 32'h2);
    store(32'h0000_E008, 4'hF, 32'h3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("async_rst_empty", {31'b0, sb_empty},      32'd1);
    #2 rst = 1'b0;
    cyc();
    bus_log.delete();
    store(32'h0000_D000, 4'hF, 32'h55);
    chk("post_rst_addr", mem_req_addr, 32'h0000_D000);
    mem_req_ready = 1'b1;
    cyc();
    chk("post_rst_empty", {31'b0, sb_empty}, 32'd1);
    chk("post_rst_sole_req", bus_log.size(), 32'd1);

    // randomized traffic on a small word pool to force merges and hazards
    for (int n = 0; n < 600; n++) begin
      st_valid      = ($urandom_range(0, 1) == 1);
      st_addr       = 32'h0000_5000 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      st_wstrb      = 4'($urandom_range(0, 15));
      st_wdata      = $urandom;
      ld_valid      = ($urandom_range(0, 1) == 1);
      ld_addr       = 32'h0000_5000 + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(0, 3));
      mem_req_ready = ($urandom_range(0, 9) < 6);
      cyc();
    end
    st_valid = 1'b0; st_wstrb = 4'b0000; ld_valid = 1'b0; mem_req_ready = 1'b1;
    repeat (DEPTH + 2) cyc();
    chk("random_drained", {31'b0, sb_empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
